// File: rtl/inst_fetch_unit.sv
// Instruction fetch requester: owns the PC, issues one synchronous-memory read per cycle,
// tags returned words with their PC and queues them for decode behind a valid/ready handshake.
module inst_fetch_unit #(
    parameter int unsigned     PC_W     = 11,
    parameter int unsigned     INST_W   = 32,
    parameter int unsigned     PC_STEP  = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_rd,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   inst_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   tag;
    logic              inflight;
    logic              squash;

    logic [INST_W-1:0] fifo_inst [DEPTH];
    logic [PC_W-1:0]   fifo_pc   [DEPTH];
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W-1:0]  wptr;
    logic [CNT_W-1:0]  occ;

    logic              pop;
    logic              push;
    logic [CNT_W:0]    credit_used;

    // Credit counts both queued entries and the read still in flight, so the FIFO never overflows.
    always_comb begin
        pop         = inst_valid & inst_ready;
        credit_used = {1'b0, occ} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
        imem_rd     = (state == StRun) & ~redirect & (credit_used < DEPTH_C);
        imem_addr   = pc;
        push        = inflight & ~squash & ~redirect;
    end

    always_comb begin
        inst_valid = (occ != '0);
        inst_out   = fifo_inst[rptr];
        inst_pc    = fifo_pc[rptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
        end else begin
            unique case (state)
                StIdle:  if (en)  state <= StRun;
                StRun:   if (!en) state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            tag      <= '0;
            inflight <= 1'b0;
            squash   <= 1'b0;
        end else begin
            inflight <= imem_rd;
            squash   <= redirect ? imem_rd : 1'b0;
            if (imem_rd) begin
                tag <= pc;
            end
            if (redirect) begin
                pc <= redirect_pc;
            end else if (imem_rd) begin
                pc <= pc + PC_W'(PC_STEP);
            end
        end
    end

    // Redirect flushes the queue outright; a pop in that cycle needs no separate handling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr <= '0;
            wptr <= '0;
            occ  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (redirect) begin
            rptr <= '0;
            wptr <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                fifo_inst[wptr] <= imem_data;
                fifo_pc[wptr]   <= tag;
                wptr            <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a one-cycle-latency memory model returns address-tagged
// words; each task walks a scenario cycle by cycle against hand-derived PCs and strobes.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic        redirect;
    logic [10:0] redirect_pc;
    logic        imem_rd;
    logic [10:0] imem_addr;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [10:0] inst_pc;

    int total = 0;
    int bad   = 0;

    inst_fetch_unit #(
        .PC_W    (11),
        .INST_W  (32),
        .PC_STEP (4),
        .RESET_PC(11'h000),
        .DEPTH   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_rd    (imem_rd),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [10:0] a);
        return {16'hC0DE, 5'b0, a};
    endfunction

    always @(posedge clk) begin
        imem_data <= imem_rd ? mdata(imem_addr) : 32'hBAD0_BAD0;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        cyc(); cyc(); #1;
        total++; if (imem_rd !== 1'b0) begin bad++; $display("FAIL reset_rd got=%0b exp=0", imem_rd); end
        total++; if (imem_addr !== 11'h000) begin bad++; $display("FAIL reset_addr got=%h exp=000", imem_addr); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", inst_valid); end
        total++; if (inst_out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", inst_out); end
        total++; if (inst_pc !== 11'h000) begin bad++; $display("FAIL reset_pc got=%h exp=000", inst_pc); end
    endtask

    // c0 idle, issue 4*(N-1) at cycle N, head 4*(N-3) from cycle 3
    task automatic test_stream();
        cyc(); rst = 1'b0; en = 1'b1; inst_ready = 1'b1; #1;
        total++; if (imem_rd !== 1'b0) begin bad++; $display("FAIL stream_idle_rd got=%0b exp=0", imem_rd); end
        for (int k = 0; k < 6; k++) begin
            logic [10:0] ea;
            logic [10:0] ep;
            cyc(); #1;
            ea = 11'(4 * k);
            ep = 11'(4 * (k - 2));
            total++; if (imem_rd !== 1'b1 || imem_addr !== ea) begin bad++;
                $display("FAIL stream_issue k=%0d got rd=%0b addr=%h exp rd=1 addr=%h", k, imem_rd, imem_addr, ea); end
            if (k >= 2) begin
                total++; if (inst_valid !== 1'b1 || inst_pc !== ep || inst_out !== mdata(ep)) begin bad++;
                    $display("FAIL stream_out k=%0d got v=%0b pc=%h d=%h exp v=1 pc=%h d=%h",
                             k, inst_valid, inst_pc, inst_out, ep, mdata(ep)); end
            end else begin
                total++; if (inst_valid !== 1'b0) begin bad++;
                    $display("FAIL stream_latency k=%0d got v=%0b exp v=0", k, inst_valid); end
            end
        end
    endtask

    // head 16 held with 20 queued behind it; pc parked at 24
    task automatic test_stall();
        cyc(); inst_ready = 1'b0; #1;
        for (int h = 0; h < 6; h++) begin
            if (h > 0) begin cyc(); #1; end
            total++; if (imem_rd !== 1'b0) begin bad++; $display("FAIL stall_rd h=%0d got=%0b exp=0", h, imem_rd); end
            total++; if (inst_valid !== 1'b1 || inst_pc !== 11'h010 || inst_out !== mdata(11'h010)) begin bad++;
                $display("FAIL stall_hold h=%0d got v=%0b pc=%h d=%h exp v=1 pc=010", h, inst_valid, inst_pc, inst_out); end
        end
        cyc(); inst_ready = 1'b1; #1;
        for (int k = 0; k < 4; k++) begin
            logic [10:0] ep;
            logic [10:0] ea;
            if (k > 0) begin cyc(); #1; end
            ep = 11'(16 + 4 * k);
            ea = 11'(24 + 4 * k);
            total++; if (inst_valid !== 1'b1 || inst_pc !== ep) begin bad++;
                $display("FAIL stall_release k=%0d got v=%0b pc=%h exp v=1 pc=%h", k, inst_valid, inst_pc, ep); end
            total++; if (imem_rd !== 1'b1 || imem_addr !== ea) begin bad++;
                $display("FAIL stall_resume k=%0d got rd=%0b addr=%h exp rd=1 addr=%h", k, imem_rd, imem_addr, ea); end
        end
    endtask

    // redirect while read of 36 is in flight and 32 sits at the head
    task automatic test_redirect();
        cyc(); redirect = 1'b1; redirect_pc = 11'h100; #1;
        total++; if (imem_rd !== 1'b0) begin bad++; $display("FAIL redir_rd got=%0b exp=0", imem_rd); end
        cyc(); redirect = 1'b0; #1;
        total++; if (imem_rd !== 1'b1 || imem_addr !== 11'h100) begin bad++;
            $display("FAIL redir_issue got rd=%0b addr=%h exp rd=1 addr=100", imem_rd, imem_addr); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL redir_squash1 got v=%0b pc=%h exp v=0", inst_valid, inst_pc); end
        cyc(); #1;
        total++; if (inst_valid !== 1'b0 || imem_addr !== 11'h104) begin bad++;
            $display("FAIL redir_squash2 got v=%0b addr=%h exp v=0 addr=104", inst_valid, imem_addr); end
        cyc(); #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 11'h100 || inst_out !== mdata(11'h100)) begin bad++;
            $display("FAIL redir_first got v=%0b pc=%h d=%h exp v=1 pc=100", inst_valid, inst_pc, inst_out); end
        cyc(); #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 11'h104) begin bad++;
            $display("FAIL redir_second got v=%0b pc=%h exp v=1 pc=104", inst_valid, inst_pc); end
    endtask

    // two redirects back to back, the second to 0x7F8 so the stream wraps through 0x000
    task automatic test_wrap();
        cyc(); redirect = 1'b1; redirect_pc = 11'h200; #1;
        total++; if (imem_rd !== 1'b0) begin bad++; $display("FAIL b2b_rd got=%0b exp=0", imem_rd); end
        cyc(); redirect_pc = 11'h7F8; #1;
        total++; if (inst_valid !== 1'b0 || imem_rd !== 1'b0) begin bad++;
            $display("FAIL b2b_flush got v=%0b rd=%0b exp v=0 rd=0", inst_valid, imem_rd); end
        cyc(); redirect = 1'b0; #1;
        for (int k = 0; k < 5; k++) begin
            logic [10:0] ea;
            logic [10:0] ep;
            if (k > 0) begin cyc(); #1; end
            ea = 11'h7F8 + 11'(4 * k);
            ep = 11'h7F8 + 11'(4 * (k - 2));
            total++; if (imem_rd !== 1'b1 || imem_addr !== ea) begin bad++;
                $display("FAIL wrap_addr k=%0d got rd=%0b addr=%h exp rd=1 addr=%h", k, imem_rd, imem_addr, ea); end
            if (k >= 2) begin
                total++; if (inst_valid !== 1'b1 || inst_pc !== ep || inst_out !== mdata(ep)) begin bad++;
                    $display("FAIL wrap_tag k=%0d got v=%0b pc=%h d=%h exp pc=%h", k, inst_valid, inst_pc, inst_out, ep); end
            end
        end
    endtask

    // drop en while streaming: the last read (0x00C) still lands, nothing issues until en returns
    task automatic test_en_drop();
        cyc(); en = 1'b0; #1;
        total++; if (imem_rd !== 1'b1 || imem_addr !== 11'h00C || inst_pc !== 11'h004) begin bad++;
            $display("FAIL endrop_last got rd=%0b addr=%h pc=%h exp rd=1 addr=00c pc=004", imem_rd, imem_addr, inst_pc); end
        cyc(); #1;
        total++; if (imem_rd !== 1'b0 || imem_addr !== 11'h010 || inst_valid !== 1'b1 || inst_pc !== 11'h008) begin bad++;
            $display("FAIL endrop_c1 got rd=%0b addr=%h v=%0b pc=%h exp rd=0 addr=010 v=1 pc=008",
                     imem_rd, imem_addr, inst_valid, inst_pc); end
        cyc(); #1;
        total++; if (imem_rd !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 11'h00C || inst_out !== mdata(11'h00C)) begin bad++;
            $display("FAIL endrop_inflight got rd=%0b v=%0b pc=%h d=%h exp rd=0 v=1 pc=00c", imem_rd, inst_valid, inst_pc, inst_out); end
        cyc(); #1;
        total++; if (imem_rd !== 1'b0 || inst_valid !== 1'b0) begin bad++;
            $display("FAIL endrop_drain got rd=%0b v=%0b exp rd=0 v=0", imem_rd, inst_valid); end
        cyc(); en = 1'b1; #1;
        total++; if (imem_rd !== 1'b0) begin bad++; $display("FAIL enup_idle got rd=%0b exp=0", imem_rd); end
        cyc(); #1;
        total++; if (imem_rd !== 1'b1 || imem_addr !== 11'h010) begin bad++;
            $display("FAIL enup_resume got rd=%0b addr=%h exp rd=1 addr=010", imem_rd, imem_addr); end
        cyc(); #1;
        total++; if (imem_addr !== 11'h014) begin bad++; $display("FAIL enup_next got addr=%h exp=014", imem_addr); end
        cyc(); #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 11'h010) begin bad++;
            $display("FAIL enup_out got v=%0b pc=%h exp v=1 pc=010", inst_valid, inst_pc); end
    endtask

    task automatic test_reset_mid();
        cyc(); #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 11'h014) begin bad++;
            $display("FAIL midrst_pre got v=%0b pc=%h exp v=1 pc=014", inst_valid, inst_pc); end
        rst = 1'b1; #1;
        total++; if (inst_valid !== 1'b0 || imem_addr !== 11'h000 || imem_rd !== 1'b0) begin bad++;
            $display("FAIL midrst_now got v=%0b addr=%h rd=%0b exp v=0 addr=000 rd=0", inst_valid, imem_addr, imem_rd); end
        total++; if (inst_out !== 32'h0 || inst_pc !== 11'h000) begin bad++;
            $display("FAIL midrst_out got d=%h pc=%h exp 0", inst_out, inst_pc); end
        cyc(); rst = 1'b0; #1;
        total++; if (imem_rd !== 1'b0 || inst_valid !== 1'b0) begin bad++;
            $display("FAIL midrst_idle got rd=%0b v=%0b exp 0", imem_rd, inst_valid); end
        cyc(); #1;
        total++; if (imem_rd !== 1'b1 || imem_addr !== 11'h000) begin bad++;
            $display("FAIL midrst_restart got rd=%0b addr=%h exp rd=1 addr=000", imem_rd, imem_addr); end
        cyc(); #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale got v=%0b pc=%h exp v=0", inst_valid, inst_pc); end
        cyc(); #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 11'h000 || inst_out !== mdata(11'h000)) begin bad++;
            $display("FAIL midrst_first got v=%0b pc=%h d=%h exp v=1 pc=000", inst_valid, inst_pc, inst_out); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_en_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
